ahb_arbiter: RTL and testbench

AHB_ARBITER -- requirements
Module: ahb_arbiter

---
 rtl/ahb_arb_if.sv | 26 ++
 rtl/ahb_arbiter.sv | 127 ++++++++++++
 tb/tb_ahb_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ahb_arb_if.sv
// AHB arbiter bus bundle: master requests and transfer qualifiers in, grant and
// owner indices out. The slave modport is the arbiter's view.
interface ahb_arb_if #(
    parameter int unsigned NUM_MASTERS = 4
);
    localparam int unsigned MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [NUM_MASTERS-1:0] i_hbusreq;
    logic                   i_hready;
    logic [1:0]             i_htrans;
    logic [2:0]             i_hburst;
    logic [1:0]             i_hresp;
    logic [NUM_MASTERS-1:0] o_hgrant;
    logic [MW-1:0]          o_hmaster;
    logic [MW-1:0]          o_hmaster_data;

    modport master (
        output i_hbusreq, i_hready, i_htrans, i_hburst, i_hresp,
        input  o_hgrant, o_hmaster, o_hmaster_data
    );

    modport slave (
        input  i_hbusreq, i_hready, i_htrans, i_hburst, i_hresp,
        output o_hgrant, o_hmaster, o_hmaster_data
    );
endinterface

// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter with hold-time limit and address/data owner tracking.
// Define AHB_ARB_BURST_LOCK_EN to keep the grant for the length of fixed-length bursts.
module ahb_arbiter #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned MAX_HOLD    = 16
) (
    input logic      i_hclk,
    input logic      i_hreset,
    ahb_arb_if.slave bus
);
    localparam int unsigned MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int unsigned BW = 4;

    // grant_idx doubles as the round-robin pointer: it only moves with the grant
    logic [NUM_MASTERS-1:0] grant, next_grant;
    logic [MW-1:0]          grant_idx, next_idx;
    logic [MW-1:0]          hmaster, hmaster_data;
    logic [HW-1:0]          hold_cnt, next_hold;
    logic [MW-1:0]          rr_idx, cand;
    logic                   rr_found;
    int unsigned            scan_idx;
    logic                   owner_req, others_req, hold_full, arbitrate;

`ifdef AHB_ARB_BURST_LOCK_EN
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;
    localparam logic [1:0] HRESP_OKAY    = 2'd0;

    logic [BW-1:0] beats, next_beats;
    logic          err;
`endif

    // Round-robin scan starting after the current owner, owner checked last
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        scan_idx = '0;
        cand     = '0;
        for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
            scan_idx = (32'(grant_idx) + k) % NUM_MASTERS;
            cand     = MW'(scan_idx);
            if (!rr_found && bus.i_hbusreq[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    // Winner selection and hold counter
    always_comb begin
        owner_req  = |(bus.i_hbusreq & grant);
        others_req = |(bus.i_hbusreq & ~grant);
        hold_full  = (hold_cnt >= HW'(MAX_HOLD));
`ifdef AHB_ARB_BURST_LOCK_EN
        err        = (bus.i_hresp != HRESP_OKAY);
        arbitrate  = bus.i_hready && ((beats <= BW'(1)) || err);
`else
        arbitrate  = bus.i_hready;
`endif
        next_idx = grant_idx;
        if (arbitrate) begin
            if (owner_req && !(others_req && hold_full)) begin
                next_idx = grant_idx;
            end else if (rr_found) begin
                next_idx = rr_idx;
            end else begin
                next_idx = '0;
            end
        end
        next_grant = NUM_MASTERS'(1) << next_idx;

        if (next_idx != grant_idx) begin
            next_hold = '0;
        end else if (hold_full) begin
            next_hold = hold_cnt;
        end else begin
            next_hold = hold_cnt + HW'(1);
        end
    end

`ifdef AHB_ARB_BURST_LOCK_EN
    // Beats remaining in the current fixed-length burst; an error response wins over a load
    always_comb begin
        next_beats = beats;
        if (err) begin
            next_beats = '0;
        end else if (bus.i_htrans == HTRANS_NONSEQ) begin
            case (bus.i_hburst)
                3'd2, 3'd3: next_beats = BW'(3);
                3'd4, 3'd5: next_beats = BW'(7);
                3'd6, 3'd7: next_beats = BW'(15);
                default:    next_beats = '0;
            endcase
        end else if ((bus.i_htrans == HTRANS_SEQ) && (beats != '0)) begin
            next_beats = beats - BW'(1);
        end
    end
`endif

    // All state advances only on transfer-complete cycles
    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            grant        <= NUM_MASTERS'(1);
            grant_idx    <= '0;
            hmaster      <= '0;
            hmaster_data <= '0;
            hold_cnt     <= '0;
`ifdef AHB_ARB_BURST_LOCK_EN
            beats        <= '0;
`endif
        end else if (bus.i_hready) begin
            grant        <= next_grant;
            grant_idx    <= next_idx;
            hmaster      <= grant_idx;
            hmaster_data <= hmaster;
            hold_cnt     <= next_hold;
`ifdef AHB_ARB_BURST_LOCK_EN
            beats        <= next_beats;
`endif
        end
    end

    assign bus.o_hgrant       = grant;
    assign bus.o_hmaster      = hmaster;
    assign bus.o_hmaster_data = hmaster_data;
endmodule

// File: tb/tb_ahb_arbiter.sv
// Self-checking bench for ahb_arbiter: constant vector table, corner-case sequences
// and randomized traffic against a cycle-level reference model.
module tb_ahb_arbiter;
    localparam int NM       = 4;
    localparam int MAX_HOLD = 4;
`ifdef AHB_ARB_BURST_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   compared = 0;
    int   mismatched = 0;

    ahb_arb_if #(.NUM_MASTERS(NM)) bus ();

    ahb_arbiter #(.NUM_MASTERS(NM), .MAX_HOLD(MAX_HOLD)) dut (
        .i_hclk  (clk),
        .i_hreset(rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: owner index, hold cycles, burst beats left, pipeline owners
    int m_owner, m_hold, m_beats, m_hm, m_hd;

    function automatic bit req_bit(input logic [3:0] req, input int idx);
        return ((int'(req) >> idx) & 1) == 1;
    endfunction

    task automatic model_reset();
        m_owner = 0; m_hold = 0; m_beats = 0; m_hm = 0; m_hd = 0;
    endtask

    task automatic model_edge(input logic [3:0] req, input logic rdy, input logic [1:0] tr,
                              input logic [2:0] bu, input logic [1:0] rs);
        int nxt;
        bit others;
        bit blocked;
        if (!rdy) return;
        blocked = LOCK && (m_beats > 1) && (rs == 2'd0);
        nxt = m_owner;
        if (!blocked) begin
            others = (int'(req) & ~(1 << m_owner)) != 0;
            if (!(req_bit(req, m_owner) && !(others && m_hold >= MAX_HOLD))) begin
                nxt = 0;
                for (int k = NM; k >= 1; k--)
                    if (req_bit(req, (m_owner + k) % NM)) nxt = (m_owner + k) % NM;
            end
        end
        if (LOCK) begin
            if (rs != 2'd0) m_beats = 0;
            else if (tr == 2'd2) m_beats = (int'(bu) >= 2) ? (4 << ((int'(bu) - 2) / 2)) - 1 : 0;
            else if (tr == 2'd3 && m_beats > 0) m_beats = m_beats - 1;
        end
        m_hold  = (nxt != m_owner) ? 0 : ((m_hold < MAX_HOLD) ? m_hold + 1 : m_hold);
        m_hd    = m_hm;
        m_hm    = m_owner;
        m_owner = nxt;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("grant", int'(bus.o_hgrant), 1 << m_owner);
        chk("hmaster", int'(bus.o_hmaster), m_hm);
        chk("hmaster_data", int'(bus.o_hmaster_data), m_hd);
    endtask

    task automatic drive(input logic [3:0] req, input logic rdy, input logic [1:0] tr,
                         input logic [2:0] bu, input logic [1:0] rs);
        bus.i_hbusreq = req;
        bus.i_hready  = rdy;
        bus.i_htrans  = tr;
        bus.i_hburst  = bu;
        bus.i_hresp   = rs;
    endtask

    task automatic cyc(input logic [3:0] req, input logic rdy, input logic [1:0] tr,
                       input logic [2:0] bu, input logic [1:0] rs);
        drive(req, rdy, tr, bu, rs);
        model_edge(req, rdy, tr, bu, rs);
        @(posedge clk);
        #1;
        chk_model();
    endtask

    // Asynchronous reset: outputs checked before any clock edge occurs
    task automatic do_reset();
        drive(4'b0000, 1'b1, 2'd0, 3'd0, 2'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_grant", int'(bus.o_hgrant), 1);
        chk("rst_hmaster", int'(bus.o_hmaster), 0);
        chk("rst_hmaster_data", int'(bus.o_hmaster_data), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0] req;
        logic       rdy;
        logic [3:0] g;
        int         hm;
        int         hd;
    } vec_t;

    vec_t tbl[15];

    initial begin
        // Idle, then constant 0110 requests with MAX_HOLD=4, then a stall and release
        tbl[0]  = '{4'b0000, 1'b1, 4'b0001, 0, 0};
        tbl[1]  = '{4'b0000, 1'b1, 4'b0001, 0, 0};
        tbl[2]  = '{4'b0110, 1'b1, 4'b0010, 0, 0};
        tbl[3]  = '{4'b0110, 1'b1, 4'b0010, 1, 0};
        tbl[4]  = '{4'b0110, 1'b1, 4'b0010, 1, 1};
        tbl[5]  = '{4'b0110, 1'b1, 4'b0010, 1, 1};
        tbl[6]  = '{4'b0110, 1'b1, 4'b0010, 1, 1};
        tbl[7]  = '{4'b0110, 1'b1, 4'b0100, 1, 1};
        tbl[8]  = '{4'b0110, 1'b1, 4'b0100, 2, 1};
        tbl[9]  = '{4'b0110, 1'b1, 4'b0100, 2, 2};
        tbl[10] = '{4'b0110, 1'b1, 4'b0100, 2, 2};
        tbl[11] = '{4'b0110, 1'b1, 4'b0100, 2, 2};
        tbl[12] = '{4'b0110, 1'b1, 4'b0010, 2, 2};
        tbl[13] = '{4'b0110, 1'b0, 4'b0010, 2, 2};
        tbl[14] = '{4'b0000, 1'b1, 4'b0001, 1, 2};

        drive(4'b0000, 1'b1, 2'd0, 3'd0, 2'd0);
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].req, tbl[i].rdy, 2'd0, 3'd0, 2'd0);
            model_edge(tbl[i].req, tbl[i].rdy, 2'd0, 3'd0, 2'd0);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_grant", i), int'(bus.o_hgrant), int'(tbl[i].g));
            chk($sformatf("tbl%0d_hmaster", i), int'(bus.o_hmaster), tbl[i].hm);
            chk($sformatf("tbl%0d_hmaster_data", i), int'(bus.o_hmaster_data), tbl[i].hd);
        end

        // Master 3 at hold limit, bus stalled while master 0 requests
        do_reset();
        for (int i = 0; i < 6; i++) cyc(4'b1000, 1'b1, 2'd0, 3'd0, 2'd0);
        for (int i = 0; i < 6; i++) cyc(4'b1001, 1'b0, 2'd0, 3'd0, 2'd0);
        chk("stall_grant", int'(bus.o_hgrant), 8);
        chk("stall_hmaster", int'(bus.o_hmaster), 3);
        chk("stall_hmaster_data", int'(bus.o_hmaster_data), 3);
        cyc(4'b1001, 1'b1, 2'd0, 3'd0, 2'd0);
        chk("stall_switch", int'(bus.o_hgrant), 1);

        // Master 1 INCR8 with two BUSY beats; master 2 requests from the first SEQ
        do_reset();
        for (int i = 0; i < 5; i++) cyc(4'b0010, 1'b1, 2'd0, 3'd0, 2'd0);
        cyc(4'b0010, 1'b1, 2'd2, 3'd5, 2'd0);
        begin
            logic [1:0] pat[9];
            pat = '{2'd3, 2'd3, 2'd1, 2'd3, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3};
            for (int i = 0; i < 9; i++) begin
                cyc(4'b0110, 1'b1, pat[i], 3'd5, 2'd0);
`ifdef AHB_ARB_BURST_LOCK_EN
                chk($sformatf("burst_beat%0d", i), int'(bus.o_hgrant), (i == 8) ? 4 : 2);
`endif
            end
        end

        // Same burst, RETRY on the third beat releases the lock
        do_reset();
        for (int i = 0; i < 5; i++) cyc(4'b0010, 1'b1, 2'd0, 3'd0, 2'd0);
        cyc(4'b0010, 1'b1, 2'd2, 3'd5, 2'd0);
        cyc(4'b0110, 1'b1, 2'd3, 3'd5, 2'd0);
`ifdef AHB_ARB_BURST_LOCK_EN
        chk("retry_before", int'(bus.o_hgrant), 2);
`endif
        cyc(4'b0110, 1'b1, 2'd3, 3'd5, 2'd2);
        chk("retry_switch", int'(bus.o_hgrant), 4);

        // Reset in the middle of an INCR16, then only master 2 requests
        do_reset();
        for (int i = 0; i < 5; i++) cyc(4'b0010, 1'b1, 2'd0, 3'd0, 2'd0);
        cyc(4'b0110, 1'b1, 2'd2, 3'd7, 2'd0);
        for (int i = 0; i < 4; i++) cyc(4'b0110, 1'b1, 2'd3, 3'd7, 2'd0);
        do_reset();
        cyc(4'b0100, 1'b1, 2'd0, 3'd0, 2'd0);
        chk("post_reset_grant", int'(bus.o_hgrant), 4);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            logic [3:0] req;
            logic       rdy;
            logic [1:0] tr;
            logic [2:0] bu;
            logic [1:0] rs;
            req = 4'($urandom_range(0, 15));
            rdy = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       tr = 2'd2;
                1:       tr = 2'($urandom_range(0, 1));
                default: tr = 2'd3;
            endcase
            bu = 3'($urandom_range(0, 7));
            rs = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            cyc(req, rdy, tr, bu, rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
